// File: rtl/div3_pkg.sv
// -----------------------------------------------------------------------------
// div3_pkg
// Shared definitions for the mod-3 stream classifier:
//   DIV3_DATA_W  default word width (must match the external mod-3 tree)
//   residue_t    2-bit residue type, legal values 0..2
//   norm_res()   folds the tree's raw result (where 3 also means "divisible")
//                into the canonical residue range 0..2
// -----------------------------------------------------------------------------
package div3_pkg;

   localparam int DIV3_DATA_W = 32;

   typedef logic [1:0] residue_t;

   // The digit-sum tree may finish on either 0 or 3 for a multiple of three.
   function automatic residue_t norm_res(input logic [1:0] raw);
      return (raw == 2'd3) ? 2'd0 : raw;
   endfunction

endpackage

// File: rtl/div3_sync_fifo.sv
// -----------------------------------------------------------------------------
// div3_sync_fifo
// Small synchronous FIFO, no first-word fall-through: an entry written at a
// clock edge becomes visible on dout after that edge.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (pointers and occupancy only)
//   push   in   write din; honoured when not full, or when full with a pop
//   din    in   WIDTH-bit write data
//   pop    in   drop the head entry; ignored when empty
//   dout   out  head entry (undefined contents when empty)
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
// -----------------------------------------------------------------------------
module div3_sync_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_BITS = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_BITS-1:0] r_count;

   logic w_do_pop;
   logic w_do_push;

   assign full  = (r_count == CNT_BITS'(DEPTH));
   assign empty = (r_count == '0);

   // A pop frees a slot in the same cycle, so a push into a full FIFO is
   // legal as long as it is paired with a pop.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   // Storage carries no reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CNT_BITS'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - CNT_BITS'(1);
         end
      end
   end

   assign dout = r_mem[r_rd_ptr];

endmodule

// File: rtl/div3_stream_classifier.sv
// -----------------------------------------------------------------------------
// div3_stream_classifier
// Streaming wrapper around an external combinational mod-3 digit-sum tree.
// Input words are registered into stage 1 (tree_in), the tree result is
// normalised to 0..2 and {word, residue} is buffered in a small FIFO for a
// valid/ready consumer. Saturating counters track pushed words.
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   s_valid    in   input word valid
//   s_ready    out  input word accepted when s_valid && s_ready
//   s_data     in   DATA_W input word
//   tree_in    out  stage-1 register, drives the external mod-3 tree
//   tree_res   in   raw tree result for tree_in (3 also means residue 0)
//   m_valid    out  FIFO head valid
//   m_ready    in   consumer pops the head on m_valid && m_ready
//   m_data     out  head word, 0 when m_valid=0
//   m_residue  out  head residue 0..2, 0 when m_valid=0
//   m_div3     out  head valid and divisible by three
//   cnt_total  out  saturating count of pushed words
//   cnt_div3   out  saturating count of pushed words with residue 0
// -----------------------------------------------------------------------------
module div3_stream_classifier
   import div3_pkg::*;
#(
   parameter int DATA_W     = DIV3_DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic [DATA_W-1:0] tree_in,
   input  logic [1:0]        tree_res,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [1:0]        m_residue,
   output logic              m_div3,
   output logic [CNT_W-1:0]  cnt_total,
   output logic [CNT_W-1:0]  cnt_div3
);

   localparam int ENTRY_W = DATA_W + 2;

   logic              r_s1_valid;
   logic [DATA_W-1:0] r_tree_in;
   logic [CNT_W-1:0]  r_cnt_total;
   logic [CNT_W-1:0]  r_cnt_div3;

   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic [ENTRY_W-1:0] w_fifo_head;
   logic [ENTRY_W-1:0] w_fifo_din;
   logic               w_pop;
   logic               w_advance;
   logic               w_accept;
   residue_t           w_res;

   // Outputs are forced quiet while reset is held, even though the FIFO only
   // clears at the reset edge.
   assign m_valid   = !rst && !w_fifo_empty;
   assign w_pop     = m_valid && m_ready;

   // Stage 1 can drain into a full FIFO when the head leaves this cycle.
   assign w_advance = !rst && r_s1_valid && (!w_fifo_full || w_pop);
   assign s_ready   = !rst && (!r_s1_valid || w_advance);
   assign w_accept  = s_valid && s_ready;

   // The tree is combinational from tree_in, so its result is valid in the
   // same cycle the word sits in stage 1.
   assign w_res      = norm_res(tree_res);
   assign w_fifo_din = {r_tree_in, w_res};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_tree_in  <= '0;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
         r_tree_in  <= s_data;
      end else if (w_advance) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt_total <= '0;
         r_cnt_div3  <= '0;
      end else if (w_advance) begin
         if (r_cnt_total != '1) begin
            r_cnt_total <= r_cnt_total + CNT_W'(1);
         end
         if ((w_res == 2'd0) && (r_cnt_div3 != '1)) begin
            r_cnt_div3 <= r_cnt_div3 + CNT_W'(1);
         end
      end
   end

   div3_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_advance),
      .din   (w_fifo_din),
      .pop   (w_pop),
      .dout  (w_fifo_head),
      .full  (w_fifo_full),
      .empty (w_fifo_empty)
   );

   assign tree_in   = r_tree_in;
   assign m_data    = m_valid ? w_fifo_head[ENTRY_W-1:2] : '0;
   assign m_residue = m_valid ? w_fifo_head[1:0] : 2'd0;
   assign m_div3    = m_valid && (w_fifo_head[1:0] == 2'd0);
   assign cnt_total = r_cnt_total;
   assign cnt_div3  = r_cnt_div3;

endmodule
